uart_word_tx: RTL and testbench
===============================

# uart_word_tx

Serial transmitter that takes a parallel word from a write strobe, splits it into bytes, and drives a standard 8N1 asynchronous serial line. It is the transmitting end of the UART link into the MIPS single-cycle system: it converts a host-side `UART_DATA`/`W_UART` word into the serial stream that the processor's UART receive path consumes. It also serves as the stimulus source in system benches.

## Interface
- `BIT_WIDTH`, 32, width of the parallel word; must be a multiple of 8. Bytes per word: `NBYTES = BIT_WIDTH/8`.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; minimum 2. Use 868 for 100 MHz / 115200 baud.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `W_UART`  in  1  write strobe; a word is accepted on any rising edge where `W_UART=1` and `BUSY=0`.
- `UART_DATA`  in  BIT_WIDTH  word to transmit; sampled only on the accepting edge.
- `UART_TX`  out  1  serial line, idle high, registered.
- `BUSY`  out  1  high from the accepting edge until the last stop bit completes.
- `DONE`  out  1  one-cycle pulse when the word finishes.

## Operation
- State machine: IDLE, START, DATA, STOP.
- **IDLE**
  - `UART_TX=1`, `BUSY=0`.
  - On `W_UART=1`: latch `UART_DATA` into the shift register, clear the byte index, bit index and baud counter, then go to START.
- **START**: `UART_TX=0` for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - Drive the current byte's bit `[bit_idx]`, LSB first, each bit for `CLKS_PER_BIT` cycles.
  - After bit 7, go to STOP.
- **STOP**
  - `UART_TX=1` for `CLKS_PER_BIT` cycles.
  - If `byte_idx < NBYTES-1`: increment `byte_idx` and go to START. There is no inter-byte idle gap.
  - Otherwise go to IDLE and pulse `DONE`.
- Byte order: `UART_DATA[7:0]` goes first and `UART_DATA[BIT_WIDTH-1:BIT_WIDTH-8]` goes last (little-endian).
- Counter widths:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0 to `CLKS_PER_BIT-1`, then wraps to 0 and advances the bit.
  - `bit_idx`: 3 bits.
  - `byte_idx`: `$clog2(NBYTES)` bits, with a minimum of 1.
- `W_UART` while `BUSY=1` is ignored. It is not queued, and the latched word is unaffected by later `UART_DATA` changes.
- `W_UART` held high continuously: a new word is accepted on the first edge where `BUSY=0`, which is the edge right after `DONE`.
- Reset values, asserted asynchronously:
  - `UART_TX=1`, `BUSY=0`, `DONE=0`.
  - State IDLE, all counters 0, shift register 0.
- Reset mid-frame abandons the word. The line returns high immediately with no stop-bit completion, and no `DONE` is produced.

## Timing
- Let edge E be the accepting edge.
- `BUSY=1` and `UART_TX=0` (start bit) are both visible after edge E.
- Bit k of a frame (0 = start, 1..8 = data, 9 = stop) occupies the cycles after edges E+k·C through E+(k+1)·C−1, where C = `CLKS_PER_BIT`.
- Byte b's frame begins at edge E+10·C·b.
- After edge E+10·C·NBYTES: `UART_TX=1`, `BUSY=0`, `DONE=1` for exactly one cycle.
- Word latency from acceptance to `DONE` is 10·C·NBYTES cycles: 640 cycles at the defaults, 40 bit times.
- Maximum throughput: one word per 10·C·NBYTES + 1 cycles.
- `W_UART` sampled at edge E+10·C·NBYTES is ignored, because `BUSY` was 1 at that edge. The earliest next accept is edge E+10·C·NBYTES+1.

## Test plan
- **Reset state**: hold `rst=1` for 5 cycles, then release. `UART_TX=1`, `BUSY=0`, `DONE=0`, and the outputs stay idle with `W_UART=0` for 100 cycles.
- **Default word**: `W_UART=1` with `UART_DATA=32'h5`, defaults. The bench-side receiver decodes bytes 05, 00, 00, 00. Every bit is 16 cycles wide and the start edge comes 1 cycle after the strobe. `DONE` pulses exactly 640 cycles after acceptance, and `BUSY` falls in the same cycle.
- **Pattern word**: `UART_DATA=32'hA5C3_3C5A` gives bytes 5A, 3C, C3, A5. Check the bits LSB first, the stop bits high, and no idle gap between bytes.
- **Busy ignore**: strobe `32'h1111_1111`, then strobe `32'hFFFF_FFFF` at cycle 100. Only the 1111_1111 word is transmitted, and exactly one `DONE` occurs.
- **Back-to-back**: hold `W_UART=1` with `UART_DATA=32'h0000_00FF` held constant. The second start bit begins 641 cycles after the first, and `DONE` pulses once per word.
- **Reset mid-frame**: assert `rst` at cycle 300 of a word. `UART_TX` goes to 1 and `BUSY` to 0 immediately, no `DONE` pulse occurs, and a new word after release transmits correctly.

Source files
------------

// File: rtl/uart_word_tx.sv
// 8N1 serial transmitter: accepts a parallel word on a write strobe and sends it
// byte by byte, least significant byte first, with no idle gap between bytes.
module uart_word_tx #(
  parameter int unsigned BIT_WIDTH    = 32,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 W_UART,
  input  logic [BIT_WIDTH-1:0] UART_DATA,
  output logic                 UART_TX,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned NBytes = BIT_WIDTH / 8;
  localparam int unsigned CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ByteW  = (NBytes > 1) ? $clog2(NBytes) : 1;

  localparam logic [CntW-1:0]  CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ByteW-1:0] ByteMax = ByteW'(NBytes - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [ByteW-1:0]       byte_q, byte_d;
  logic [BIT_WIDTH-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   baud_tick;

  assign baud_tick = (cnt_q == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // The shift register drops one bit per data bit sent, so after a byte the next
  // byte's LSB is already at position 0 for the following frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (W_UART) begin
          shift_d = UART_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (baud_tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (baud_tick) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (baud_tick) begin
          cnt_d = '0;
          if (byte_q == ByteMax) begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            byte_d  = byte_q + 1'b1;
            tx_d    = 1'b0;
            state_d = StStart;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  assign UART_TX = tx_q;
  assign BUSY    = (state_q != StIdle);
  assign DONE    = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: table of words checked cycle by cycle against
// an ideal 8N1 waveform, plus back-to-back, busy-ignore and mid-frame reset cases.
module tb_uart_word_tx;

  localparam int C   = 16;
  localparam int W   = 32;
  localparam int NB  = W / 8;
  localparam int Lat = 10 * C * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         W_UART;
  logic [W-1:0] UART_DATA;
  logic         UART_TX;
  logic         BUSY;
  logic         DONE;

  int checks = 0;
  int passes = 0;

  uart_word_tx #(
    .BIT_WIDTH   (W),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .W_UART   (W_UART),
    .UART_DATA(UART_DATA),
    .UART_TX  (UART_TX),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [31:0] exp;
    int          poke_at;
    logic [31:0] poke_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passes++;
  endtask

  // Sends one word and checks every cycle from the accepting edge to DONE.
  task automatic run_frame(input string name, input logic [31:0] data,
                           input logic [31:0] exp, input int poke_at,
                           input logic [31:0] poke_data);
    int          wave_err = 0;
    int          frame_err = 0;
    int          done_cnt = 0;
    int          done_t = -1;
    int          busy_fall = -1;
    int          f, k;
    logic [4:0]  idx;
    logic [31:0] rx = '0;
    logic        e_tx, e_busy, e_done;
    W_UART    = 1'b1;
    UART_DATA = data;
    @(posedge clk);
    @(negedge clk);
    W_UART    = 1'b0;
    UART_DATA = ~data;
    for (int t = 0; t <= Lat; t++) begin
      if (t > 0) @(negedge clk);
      f = t / (10 * C);
      k = (t % (10 * C)) / C;
      if (t < Lat) begin
        idx    = 5'(f * 8 + k - 1);
        e_tx   = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp[idx];
        e_busy = 1'b1;
        e_done = 1'b0;
      end else begin
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b1;
      end
      if (UART_TX !== e_tx || BUSY !== e_busy || DONE !== e_done) wave_err++;
      if (DONE === 1'b1) begin
        done_cnt++;
        done_t = t;
      end
      if (busy_fall < 0 && BUSY !== 1'b1) busy_fall = t;
      if (t < Lat && (t % C) == C / 2) begin
        if (k == 0 && UART_TX !== 1'b0) frame_err++;
        else if (k == 9 && UART_TX !== 1'b1) frame_err++;
        else if (k >= 1 && k <= 8) rx[5'(f * 8 + k - 1)] = UART_TX;
      end
      if (t == poke_at) begin
        W_UART    = 1'b1;
        UART_DATA = poke_data;
      end else if (t == poke_at + 1) begin
        W_UART = 1'b0;
      end
    end
    chk({name, " decoded"}, rx, exp);
    chk({name, " waveform errors"}, 32'(wave_err), 32'd0);
    chk({name, " framing errors"}, 32'(frame_err), 32'd0);
    chk({name, " done count"}, 32'(done_cnt), 32'd1);
    chk({name, " done cycle"}, 32'(done_t), 32'(Lat));
    chk({name, " busy fall cycle"}, 32'(busy_fall), 32'(Lat));
    @(negedge clk);
    chk({name, " done width"}, {31'd0, DONE}, 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    int   err;
    int   d_cnt, d1, d2;
    logic tx640, tx641;
    logic [31:0] rx2;

    vecs[0] = '{"default", 32'h0000_0005, 32'h0000_0005, -1, 32'h0};
    vecs[1] = '{"pattern", 32'hA5C3_3C5A, 32'hA5C3_3C5A, -1, 32'h0};
    vecs[2] = '{"busy ignore", 32'h1111_1111, 32'h1111_1111, 100, 32'hFFFF_FFFF};
    vecs[3] = '{"mixed", 32'h8001_7EFF, 32'h8001_7EFF, -1, 32'h0};

    rst       = 1'b1;
    W_UART    = 1'b0;
    UART_DATA = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {29'd0, UART_TX, BUSY, DONE}, 32'b100);
    rst = 1'b0;
    err = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (UART_TX !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) err++;
    end
    chk("idle after reset", 32'(err), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].name, vecs[i].data, vecs[i].exp, vecs[i].poke_at, vecs[i].poke_data);
      repeat (3) @(negedge clk);
    end

    // Back-to-back with W_UART held high: second start at t = Lat + 1.
    W_UART    = 1'b1;
    UART_DATA = 32'h0000_00FF;
    @(posedge clk);
    d_cnt = 0;
    d1    = -1;
    d2    = -1;
    tx640 = 1'b0;
    tx641 = 1'b1;
    rx2   = '0;
    for (int t = 0; t <= 2 * Lat + 10; t++) begin
      @(negedge clk);
      if (DONE === 1'b1) begin
        d_cnt++;
        if (d1 < 0) d1 = t;
        else d2 = t;
      end
      if (t == Lat) tx640 = UART_TX;
      if (t == Lat + 1) begin
        tx641  = UART_TX;
        W_UART = 1'b0;
      end
      if (t > Lat && t < 2 * Lat + 1 && ((t - Lat - 1) % (10 * C)) / C >= 1 &&
          ((t - Lat - 1) % (10 * C)) / C <= 8 && ((t - Lat - 1) % C) == C / 2)
        rx2[5'(((t - Lat - 1) / (10 * C)) * 8 + ((t - Lat - 1) % (10 * C)) / C - 1)] = UART_TX;
    end
    chk("b2b done count", 32'(d_cnt), 32'd2);
    chk("b2b first done", 32'(d1), 32'(Lat));
    chk("b2b second done", 32'(d2), 32'(2 * Lat + 1));
    chk("b2b stop then start", {30'd0, tx640, tx641}, 32'b10);
    chk("b2b second word", rx2, 32'h0000_00FF);

    // Reset in the middle of byte 1, data bit 7 (line low for an all-zero word).
    W_UART    = 1'b1;
    UART_DATA = 32'h0000_0000;
    @(posedge clk);
    @(negedge clk);
    W_UART = 1'b0;
    repeat (300) @(negedge clk);
    chk("pre-reset line", {30'd0, UART_TX, BUSY}, 32'b01);
    #2 rst = 1'b1;
    #1 chk("async reset outputs", {29'd0, UART_TX, BUSY, DONE}, 32'b100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    err = 0;
    for (int i = 0; i < Lat + 20; i++) begin
      @(negedge clk);
      if (UART_TX !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) err++;
    end
    chk("no done after abort", 32'(err), 32'd0);
    run_frame("post-reset", 32'hDEAD_BEEF, 32'hDEAD_BEEF, -1, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
